tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter: TIMEOUT, 4096, max cycles in WAIT before abort (>=4).
REQ-003 Port: clk  in  1  single clock, all logic on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: req  in  N_REQ  per-requester level request, held until its ack.
REQ-006 Port: req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
REQ-007 Port: grant  out  N_REQ  one-hot owner of transmitter, zero when idle.
REQ-008 Port: ack  out  N_REQ  one-cycle completion pulse to owner.
REQ-009 Port: timeout  out  1  one-cycle pulse, coincident with ack, when transfer aborted.
REQ-010 Port: busy  out  1  high in every state except IDLE.
REQ-011 Port: tx_start  out  1  one-cycle start pulse to transmitter control unit.
REQ-012 Port: tx_data  out  8  registered byte to transmitter, stable while grant nonzero.
REQ-013 Port: tx_done  in  1  one-cycle completion pulse from transmitter control unit.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT, RELEASE; state register updates on clk.
REQ-015 IDLE, req==0: remain IDLE; grant, ack, tx_start, timeout all 0.
REQ-016 IDLE, req!=0: at the edge, register one-hot grant for winner, register tx_data from winner's req_data slice, go START.
REQ-017 Winner: first set bit of req scanning ptr+1, ptr+2, ... modulo N_REQ, wrapping; ptr = index of last served requester.
REQ-018 START: tx_start=1 for exactly this one cycle; unconditionally go WAIT; tx_done here ignored.
REQ-019 WAIT: cycle counter increments from 0 each cycle; tx_done=1 -> go RELEASE, timeout flag cleared.
REQ-020 WAIT: counter reaches TIMEOUT-1 without tx_done -> go RELEASE with timeout flag set; tx_done in that same cycle takes priority (normal completion).
REQ-021 RELEASE: ack = grant for one cycle; timeout=1 only if aborted; ptr <= winner index; grant cleared at exit edge; go IDLE.
REQ-022 Minimum cycles per byte: IDLE sample edge -> START (1) -> WAIT (>=1) -> RELEASE (1) -> IDLE; new arbitration earliest in cycle after RELEASE.
REQ-023 Requester still asserting req in cycle after its ack SHALL be treated as a new request and ranked lowest (ptr points to it).
REQ-024 req dropped by owner during START/WAIT: transfer completes normally, ack still pulses.
REQ-025 req_data changes after grant SHALL NOT affect tx_data.
REQ-026 tx_done outside WAIT SHALL be ignored; no spurious ack.
REQ-027 Counter width ceil(log2(TIMEOUT)); counter cleared on entry to WAIT; no wrap observable.
REQ-028 busy = (state != IDLE), decoded combinationally from state register.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, grant=0, ack=0, timeout=0, tx_start=0, busy=0, tx_data=0, counter=0.
REQ-030 Reset sets ptr=N_REQ-1 so requester 0 has highest priority at first arbitration.
REQ-031 Reset asserted mid-transfer SHALL abort without ack; no pulse emitted on deassertion.

Verification
REQ-032 Single req: req=4'b0100, data 8'hA5, tx_done 10 cycles after tx_start -> grant=4'b0100, tx_data=8'hA5, tx_start one cycle, ack=4'b0100 one cycle, timeout=0.
REQ-033 Fairness: req=4'b1111 held, each acked then re-raised -> grants in order 0,1,2,3,0; no requester served twice before others.
REQ-034 Timeout: TIMEOUT=16, tx_done never asserted -> RELEASE after 16 WAIT cycles, ack and timeout pulse together, next requester served.
REQ-035 Races: tx_done in START cycle ignored; tx_done on final timeout cycle -> ack with timeout=0.
REQ-036 Reset mid-WAIT with grant=4'b0010 -> all outputs 0 asynchronously; after release, req=4'b0011 -> requester 0 granted first.
REQ-037 Owner drops req and changes req_data during WAIT -> tx_data unchanged, ack still pulses on tx_done.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// Bundle of signals between the requesters/transmitter side and the TX arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   ack;
  logic               timeout;
  logic               busy;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;

  modport slave (
    input  req, req_data, tx_done,
    output grant, ack, timeout, busy, tx_start, tx_data
  );

  modport master (
    output req, req_data, tx_done,
    input  grant, ack, timeout, busy, tx_start, tx_data
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// One byte per grant: IDLE -> START -> WAIT (until tx_done or timeout) -> RELEASE.
module tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  tx_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [7:0]       data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             to_q, to_d;

  logic [PW-1:0]    win_idx;
  logic             any_req;

  // Scan ptr+1, ptr+2, ... wrapping; the last served requester ranks lowest.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [PW-1:0]    p);
    logic [PW-1:0] pick;
    int            idx;
    pick = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(p) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (r[idx]) pick = PW'(idx);
    end
    return pick;
  endfunction

  assign any_req = |bus.req;
  assign win_idx = rr_pick(bus.req, ptr_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          data_d  = bus.req_data[{win_idx, 3'b000} +: 8];
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last allowed cycle still counts as normal.
        if (bus.tx_done) begin
          to_d    = 1'b0;
          state_d = S_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        ptr_d   = owner_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      owner_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Pulses are decoded from the state register so reset clears them at once.
  assign bus.grant    = grant_q;
  assign bus.ack      = (state_q == S_RELEASE) ? grant_q : '0;
  assign bus.timeout  = (state_q == S_RELEASE) && to_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tx_start = (state_q == S_START);
  assign bus.tx_data  = data_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: expected grants are queued when requests are
// raised and retired by a monitor whenever the arbiter pulses ack.
module tb_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;

  tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0] g;
    logic [7:0]       d;
    logic             to;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic push(input logic [N_REQ-1:0] g, input logic [7:0] d, input logic to);
    exp_t e;
    e.g = g; e.d = d; e.to = to;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack retires the oldest expected transfer.
  always @(negedge clk) begin
    if (rst_n && bus.ack != '0) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'(bus.ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_vec", 32'(bus.ack), 32'(e.g));
        chk("ack_grant", 32'(bus.grant), 32'(e.g));
        chk("ack_data", 32'(bus.tx_data), 32'(e.d));
        chk("ack_timeout", 32'(bus.timeout), 32'(e.to));
      end
    end
    if (rst_n && bus.timeout && bus.ack == '0)
      chk("timeout_without_ack", 32'(bus.timeout), 32'h0);
  end

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!bus.tx_start && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 32'(bus.tx_start), 32'h1);
  endtask

  // Runs one transfer from tx_start; dly=0 means tx_done is never sent.
  // Returns in the RELEASE (ack) cycle.
  task automatic do_xfer(input string tag, input int dly, input bit done_in_start,
                         input bit drop, input int exp_wait);
    int n;
    wait_start(tag);
    if (sb.size() > 0) begin
      chk({tag, "_grant"}, 32'(bus.grant), 32'(sb[0].g));
      chk({tag, "_txdata"}, 32'(bus.tx_data), 32'(sb[0].d));
    end
    if (done_in_start) bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk({tag, "_start_1cyc"}, 32'(bus.tx_start), 32'h0);
    if (drop) begin
      bus.req      = '0;
      bus.req_data = ~bus.req_data;
    end
    if (dly > 0) begin
      repeat (dly - 1) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
    n = 0;
    while (bus.ack == '0 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_ack_seen"}, 32'(bus.ack != '0), 32'h1);
    chk({tag, "_ack_latency"}, 32'(n), 32'(exp_wait));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;
    repeat (2) tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_start", 32'(bus.tx_start), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    chk("rst_txdata", 32'(bus.tx_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single requester, completion 10 cycles after tx_start.
    bus.req_data = 32'h00A5_0000;
    bus.req      = 4'b0100;
    push(4'b0100, 8'hA5, 1'b0);
    do_xfer("single", 10, 1'b0, 1'b0, 0);
    bus.req = '0;
    tick();
    chk("single_idle_busy", 32'(bus.busy), 32'h0);
    chk("single_idle_grant", 32'(bus.grant), 32'h0);

    // Fairness from reset: all held, served 0,1,2,3,0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_data = 32'h1312_1110;
    bus.req      = 4'b1111;
    push(4'b0001, 8'h10, 1'b0);
    push(4'b0010, 8'h11, 1'b0);
    push(4'b0100, 8'h12, 1'b0);
    push(4'b1000, 8'h13, 1'b0);
    push(4'b0001, 8'h10, 1'b0);
    for (int k = 0; k < 5; k++) begin
      do_xfer("rr", 3, 1'b0, 1'b0, 0);
      if (k == 4) bus.req = '0;
    end
    tick();

    // Timeout on requester 1, then requester 3 served normally.
    bus.req_data = 32'hD3C3_B3A3;
    bus.req      = 4'b1010;
    push(4'b0010, 8'hB3, 1'b1);
    push(4'b1000, 8'hD3, 1'b0);
    do_xfer("tmo", 0, 1'b0, 1'b0, TIMEOUT);
    bus.req = 4'b1000;
    do_xfer("after_tmo", 4, 1'b0, 1'b0, 0);
    bus.req = '0;
    tick();

    // tx_done while idle is ignored.
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("idle_done_ack", 32'(bus.ack), 32'h0);
    chk("idle_done_busy", 32'(bus.busy), 32'h0);

    // tx_done in START ignored; tx_done on the last WAIT cycle wins over timeout.
    bus.req_data = 32'h0000_0077;
    bus.req      = 4'b0001;
    push(4'b0001, 8'h77, 1'b0);
    do_xfer("race", TIMEOUT, 1'b1, 1'b0, 0);
    bus.req = '0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    bus.req_data = 32'h0000_5500;
    bus.req      = 4'b0010;
    wait_start("rstmid");
    chk("rstmid_grant", 32'(bus.grant), 32'h2);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_grant0", 32'(bus.grant), 32'h0);
    chk("rstmid_ack0", 32'(bus.ack), 32'h0);
    chk("rstmid_busy0", 32'(bus.busy), 32'h0);
    chk("rstmid_start0", 32'(bus.tx_start), 32'h0);
    chk("rstmid_txdata0", 32'(bus.tx_data), 32'h0);
    bus.req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_after_busy", 32'(bus.busy), 32'h0);
    bus.req_data = 32'h0000_6644;
    bus.req      = 4'b0011;
    push(4'b0001, 8'h44, 1'b0);
    push(4'b0010, 8'h66, 1'b0);
    do_xfer("post_rst0", 2, 1'b0, 1'b0, 0);
    bus.req = 4'b0010;
    do_xfer("post_rst1", 2, 1'b0, 1'b0, 0);
    bus.req = '0;
    tick();

    // Owner drops req and changes its data mid-WAIT.
    bus.req_data = 32'h00A5_0000;
    bus.req      = 4'b0100;
    push(4'b0100, 8'hA5, 1'b0);
    do_xfer("drop", 5, 1'b0, 1'b1, 0);
    tick();
    chk("drop_txdata_hold", 32'(bus.tx_data), 32'hA5);

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
